// File: rtl/ca2_serial.sv
// ca2_serial: chunk-serial two's-complement negate / absolute / pass with {C,V,N,Z} flags.
// One chunk per cycle, LSB chunk first; ripple carry is held in a register between cycles.
module ca2_serial #(
    parameter int         op_size = 16,
    parameter int         chunk   = 4,
    parameter logic [3:0] c_mask  = 4'b1000,
    parameter logic [3:0] v_mask  = 4'b0100,
    parameter logic [3:0] n_mask  = 4'b0010,
    parameter logic [3:0] z_mask  = 4'b0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [op_size-1:0] A,
    output logic               busy,
    output logic               done,
    output logic [op_size-1:0] R,
    output logic [3:0]         CCR
);
    localparam int nch = op_size / chunk;
    localparam int iw = nch > 1 ? $clog2(nch) : 1;
    localparam logic [op_size-1:0] min_neg = {1'b1, {(op_size-1){1'b0}}};

    if (op_size % chunk != 0) begin : g_chk
        $error("ca2_serial: chunk must divide op_size exactly");
    end

    typedef enum logic [1:0] {IDLE, RUN, FLAGS} state_t;

    state_t             state;
    logic [op_size-1:0] opnd;
    logic [op_size-1:0] acc;
    logic [iw-1:0]      idx;
    logic               inv;
    logic               carry;
    logic               inv_in;
    logic [chunk-1:0]   slice;
    logic [chunk:0]     sum;
    logic               c_f;
    logic               v_f;

    // Negation is ~x + 1: the +1 enters as the initial carry of chunk 0.
    always_comb begin
        inv_in = mode == 2'b01 ? A[op_size-1] : mode != 2'b10;
        slice  = opnd[idx*chunk +: chunk];
        sum    = {1'b0, inv ? ~slice : slice} + {{chunk{1'b0}}, carry};
        c_f    = inv && opnd != '0;
        v_f    = inv && opnd == min_neg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opnd  <= '0;
            acc   <= '0;
            idx   <= '0;
            inv   <= 1'b0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            R     <= '0;
            CCR   <= 4'b0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    opnd  <= A;
                    inv   <= inv_in;
                    carry <= inv_in;
                    idx   <= '0;
                    acc   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc[idx*chunk +: chunk] <= sum[chunk-1:0];
                    carry <= sum[chunk];
                    idx   <= idx + 1'b1;
                    state <= idx == iw'(nch-1) ? FLAGS : RUN;
                end
                FLAGS: begin
                    R     <= acc;
                    CCR   <= (c_f ? c_mask : 4'b0000) | (v_f ? v_mask : 4'b0000)
                           | (acc[op_size-1] ? n_mask : 4'b0000) | (acc == '0 ? z_mask : 4'b0000);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ca2_serial.sv
// tb_ca2_serial: randomized and directed checks of ca2_serial (16/4 and 4/2 instances)
// against an integer-arithmetic reference model.
module tb_ca2_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start16 = 1'b0;
    logic [1:0]  mode16 = 2'b00;
    logic [15:0] a16 = '0;
    logic        busy16, done16;
    logic [15:0] r16;
    logic [3:0]  ccr16;
    logic        start4 = 1'b0;
    logic [1:0]  mode4 = 2'b00;
    logic [3:0]  a4 = '0;
    logic        busy4, done4;
    logic [3:0]  r4;
    logic [3:0]  ccr4;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ca2_serial #(.op_size(16), .chunk(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16), .A(a16),
        .busy(busy16), .done(done16), .R(r16), .CCR(ccr16)
    );

    ca2_serial #(.op_size(4), .chunk(2)) u4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .A(a4),
        .busy(busy4), .done(done4), .R(r4), .CCR(ccr4)
    );

    // Returns {C,V,N,Z, R} from the true signed arithmetic result wrapped to w bits.
    function automatic logic [19:0] ref_op(input int w, input logic [1:0] m, input logic [15:0] a);
        int sv, res, r;
        logic c, v, n, z;
        sv  = a[w-1] ? int'(a) - (1 << w) : int'(a);
        res = m == 2'b10 ? sv : (m == 2'b01 ? (sv < 0 ? -sv : sv) : -sv);
        r   = res & ((1 << w) - 1);
        c   = m != 2'b10 && (m == 2'b01 ? sv < 0 : sv != 0);
        v   = res > (1 << (w-1)) - 1 || res < -(1 << (w-1));
        n   = ((r >> (w-1)) & 1) != 0;
        z   = r == 0;
        return {c, v, n, z, 16'(r)};
    endfunction

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({busy16, done16, r16, ccr16} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset16 got busy=%b done=%b R=%h CCR=%b want all 0", busy16, done16, r16, ccr16);
        end
        n_cmp++;
        if ({busy4, done4, r4, ccr4} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset4 got busy=%b done=%b R=%h CCR=%b want all 0", busy4, done4, r4, ccr4);
        end
        rst = 1'b0;
    endtask

    task automatic op16(input logic [1:0] m, input logic [15:0] a, input bit pulse);
        logic [19:0] e;
        logic [15:0] r0;
        logic [3:0]  c0;
        int          n, extra;
        bit          held_ok, busy_ok;
        e = ref_op(16, m, a);
        @(negedge clk);
        start16 = 1'b1; mode16 = m; a16 = a; r0 = r16; c0 = ccr16;
        @(posedge clk); #1;
        n = 0; held_ok = 1'b1; busy_ok = busy16 === 1'b1;
        while (done16 !== 1'b1 && n < 20) begin
            @(negedge clk);
            start16 = pulse && n >= 1 && n <= 3;
            mode16  = 2'($urandom);
            a16     = 16'($urandom);
            @(posedge clk); #1;
            n++;
            if (done16 !== 1'b1 && (r16 !== r0 || ccr16 !== c0)) held_ok = 1'b0;
            if (done16 !== 1'b1 && busy16 !== 1'b1) busy_ok = 1'b0;
        end
        start16 = 1'b0;
        n_cmp++;
        if (n !== 5) begin n_bad++; $display("FAIL lat16 m=%b A=%h got %0d edges want 5", m, a, n); end
        n_cmp++;
        if (!held_ok) begin n_bad++; $display("FAIL hold16 m=%b A=%h R/CCR changed before done", m, a); end
        n_cmp++;
        if (!busy_ok) begin n_bad++; $display("FAIL busy16 m=%b A=%h busy dropped before done", m, a); end
        n_cmp++;
        if (r16 !== e[15:0]) begin n_bad++; $display("FAIL r16 m=%b A=%h got %h want %h", m, a, r16, e[15:0]); end
        n_cmp++;
        if (ccr16 !== e[19:16]) begin n_bad++; $display("FAIL ccr16 m=%b A=%h got %b want %b", m, a, ccr16, e[19:16]); end
        n_cmp++;
        if (busy16 !== 1'b0) begin n_bad++; $display("FAIL idle16 busy after done got %b want 0", busy16); end
        extra = 0;
        repeat (2) begin @(posedge clk); #1; if (done16 !== 1'b0) extra++; end
        n_cmp++;
        if (extra !== 0) begin n_bad++; $display("FAIL once16 m=%b A=%h extra done pulses %0d want 0", m, a, extra); end
    endtask

    task automatic op4(input logic [1:0] m, input logic [3:0] a);
        logic [19:0] e;
        int n;
        e = ref_op(4, m, {12'd0, a});
        @(negedge clk);
        start4 = 1'b1; mode4 = m; a4 = a;
        @(posedge clk); #1;
        start4 = 1'b0; mode4 = 2'($urandom); a4 = 4'($urandom);
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n !== 3) begin n_bad++; $display("FAIL lat4 m=%b A=%b got %0d edges want 3", m, a, n); end
        n_cmp++;
        if (r4 !== e[3:0]) begin n_bad++; $display("FAIL r4 m=%b A=%b got %b want %b", m, a, r4, e[3:0]); end
        n_cmp++;
        if (ccr4 !== e[19:16]) begin n_bad++; $display("FAIL ccr4 m=%b A=%b got %b want %b", m, a, ccr4, e[19:16]); end
    endtask

    task automatic test_directed;
        op16(2'b00, 16'h0001, 1'b0);
        op16(2'b00, 16'h0001, 1'b1);
        op16(2'b00, 16'h0000, 1'b0);
        op16(2'b01, 16'h8000, 1'b0);
        op16(2'b11, 16'h7FFF, 1'b0);
        op16(2'b01, 16'hFFFF, 1'b0);
        op16(2'b10, 16'h8000, 1'b1);
        op4(2'b01, 4'b1011);
        op4(2'b01, 4'b0101);
        op4(2'b10, 4'b1100);
    endtask

    task automatic test_exhaustive4;
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 16; a++)
                op4(2'(m), 4'(a));
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            op16(2'($urandom), 16'($urandom), 1'($urandom));
    endtask

    task automatic test_reset_mid;
        int late;
        op16(2'b00, 16'h0010, 1'b0);
        @(negedge clk);
        start16 = 1'b1; mode16 = 2'b00; a16 = 16'h1234;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy16, done16, r16, ccr16} !== 22'd0) begin
            n_bad++;
            $display("FAIL abort got busy=%b done=%b R=%h CCR=%b want all 0", busy16, done16, r16, ccr16);
        end
        @(negedge clk);
        rst = 1'b0;
        late = 0;
        repeat (8) begin @(posedge clk); #1; if (done16 !== 1'b0 || busy16 !== 1'b0) late++; end
        n_cmp++;
        if (late !== 0) begin n_bad++; $display("FAIL abort_quiet activity after abort %0d cycles want 0", late); end
        op16(2'b00, 16'h8000, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [19:0] q[$];
        logic [19:0] e;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start16 = 1'b1;
            mode16  = 2'($urandom);
            a16     = 16'($urandom);
            if (k % 6 == 0) q.push_back(ref_op(16, mode16, a16));
            @(posedge clk); #1;
            n_cmp++;
            if (done16 !== (k % 6 == 5)) begin
                n_bad++;
                $display("FAIL b2b_done edge %0d got %b want %b", k, done16, k % 6 == 5);
            end
            if (done16 === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if ({ccr16, r16} !== e) begin
                    n_bad++;
                    $display("FAIL b2b_res edge %0d got CCR=%b R=%h want CCR=%b R=%h", k, ccr16, r16, e[19:16], e[15:0]);
                end
            end
        end
        start16 = 1'b0;
        n_cmp++;
        if (q.size() !== 0) begin n_bad++; $display("FAIL b2b_count pending ops %0d want 0", q.size()); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_exhaustive4;
        test_random;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ca2_serial.md
Name: ca2_serial

Overview:
- Clocked, parametrised successor to the combinational two's-complement negator.
- Computes R = -A (NEG), R = |A| (ABS) or R = A (PASS) over op_size bits.
- Processes `chunk` bits per clock cycle, LSB chunk first, with ripple carry held between cycles.
- Produces the 4-bit condition code register (C V N Z) under a start/busy/done handshake.
- Sits beside the ALU datapath blocks and replaces `#`-delay sequencing with real cycles.

Parameters:
- op_size, 16, operand/result width in bits.
- chunk, 4, bits processed per cycle. Must divide op_size exactly; otherwise elaboration fails with an error.
- c_mask, 4'b1000, CCR carry bit.
- v_mask, 4'b0100, CCR overflow bit.
- n_mask, 4'b0010, CCR negative bit.
- z_mask, 4'b0001, CCR zero bit.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- mode  input  2  00=NEG, 01=ABS, 10=PASS, 11=NEG.
- A  input  op_size  operand; sampled on the start edge.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; R/CCR updated on the same edge.
- R  output  op_size  result register.
- CCR  output  4  {C,V,N,Z}.

Behaviour:
- Reset (async, any time): R=0, CCR=4'b0000, busy=0, done=0, FSM=IDLE, internal shift/carry registers cleared.
- Reset asserted mid-operation aborts the operation: no done pulse, and R/CCR return to 0.
- Let NCH = op_size/chunk.
- FSM states: IDLE, RUN, FLAGS.
- IDLE, start=1 at an edge: latch A into opnd, mode into md; set chunk index=0; busy<=1; go to RUN.
  - inv = 1 if md is NEG, or if md=ABS and A[op_size-1]=1; else inv = 0.
  - carry <= inv.
- RUN, each edge, for chunk idx:
  - res_chunk = (inv ? ~opnd_chunk : opnd_chunk) + carry, computed chunk+1 bits wide.
  - The low chunk bits go into internal result shift register slot idx; carry <= bit chunk.
  - idx increments. After idx = NCH-1 is processed, go to FLAGS.
- FLAGS, one edge:
  - R <= assembled result.
  - C = inv AND (A != 0). NEG: 1 iff A != 0. ABS: 1 iff A negative. PASS: 0.
  - V = inv AND (A == 1 followed by op_size-1 zeros), i.e. most-negative value, where the result equals A.
  - N = result[op_size-1].
  - Z = (result == 0).
  - CCR <= {C,V,N,Z}. All four flags are written every operation; no stale bits.
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: start edge to done edge = NCH+1 edges. NCH=1 gives 2 edges.
- start while busy=1 is ignored: no queueing, latched operands unchanged.
- start asserted on the same edge that done is issued (FLAGS edge) is ignored, because busy=1 at that edge. The next start is accepted one cycle later.
- A and mode may change freely after the start edge.
- R and CCR hold their values from the last done until the next done; they do not change during RUN.
- Most-negative input: NEG and ABS return A unchanged with V=1, C=1, N=1.
- Carry out of the final chunk is discarded; it does not affect the flags.

Test Plan:
- op_size=4, chunk=1, NEG A=4'b0011 -> R=4'b1101, CCR=4'b1010; done 5 edges after start; busy high for edges 1-4.
- op_size=4, chunk=1, NEG A=0 -> R=0, CCR=4'b0001. Then NEG A=4'b1000 -> R=4'b1000, CCR=4'b1110.
- op_size=4, chunk=2:
  - ABS A=4'b1011 -> R=4'b0101, CCR=4'b1000.
  - ABS A=4'b0101 -> R=4'b0101, CCR=4'b0000.
  - PASS A=4'b1100 -> R=4'b1100, CCR=4'b0010.
- op_size=16, chunk=4, NEG A=16'h0001 -> R=16'hFFFF, CCR=4'b1010 after 5 edges.
  - Pulse start again at edges 2-4 -> ignored; exactly one done; R/CCR unchanged until done.
- op_size=16, chunk=4:
  - Complete a NEG of A=16'h0010; assert rst at RUN edge 2 of the next op -> R=0, CCR=0, busy=0 immediately, no done.
  - After release, NEG A=16'h8000 -> R=16'h8000, CCR=4'b1110.
- Back-to-back: hold start high continuously -> operations accepted every NCH+2 edges, one done per operation.
